// File: rtl/memory_arbiter.sv
// Two-requester round-robin arbiter in front of a single memory port.
// One transaction at a time: IDLE grants, BUSY waits for ack or timeout, RESP pulses the ack.
module memory_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        r0_req_i,
  input  logic        r0_we_i,
  input  logic [31:0] r0_addr_i,
  input  logic [31:0] r0_wdata_i,
  output logic        r0_ack_o,
  output logic        r0_err_o,
  output logic [31:0] r0_rdata_o,
  input  logic        r1_req_i,
  input  logic        r1_we_i,
  input  logic [31:0] r1_addr_i,
  input  logic [31:0] r1_wdata_i,
  output logic        r1_ack_o,
  output logic        r1_err_o,
  output logic [31:0] r1_rdata_o,
  output logic        mem_enable_o,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic              gnt, gnt_nxt, last_gnt;
  logic [3:0]        wait_cnt;
  logic              err;
  logic [1:0]        req;
  logic [1:0][31:0]  rdata_q;

  assign req = {r1_req_i, r0_req_i};

  // r0 wins when alone, or on a tie when r1 had the previous grant
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    case (state)
      IDLE: if (|req) begin
        state_nxt = BUSY;
        gnt_nxt   = (req[0] && (!req[1] || last_gnt)) ? 1'b0 : 1'b1;
      end
      BUSY: if (mem_ack_i || wait_cnt == TO_LAST) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      last_gnt    <= 1'b1;
      wait_cnt    <= '0;
      err         <= 1'b0;
      mem_write_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      rdata_q     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (|req) begin
          gnt         <= gnt_nxt;
          last_gnt    <= gnt_nxt;
          wait_cnt    <= '0;
          err         <= 1'b0;
          mem_write_o <= gnt_nxt ? r1_we_i    : r0_we_i;
          mem_addr_o  <= gnt_nxt ? r1_addr_i  : r0_addr_i;
          mem_wdata_o <= gnt_nxt ? r1_wdata_i : r0_wdata_i;
        end
        // ack takes priority over a timeout landing in the same cycle
        BUSY: if (mem_ack_i) begin
          err <= 1'b0;
          if (!mem_write_o) rdata_q[gnt] <= mem_rdata_i;
        end else if (wait_cnt == TO_LAST) begin
          err <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign mem_enable_o = (state == BUSY);
  assign r0_ack_o     = (state == RESP) && !gnt;
  assign r1_ack_o     = (state == RESP) &&  gnt;
  assign r0_err_o     = r0_ack_o && err;
  assign r1_err_o     = r1_ack_o && err;
  assign r0_rdata_o   = rdata_q[0];
  assign r1_rdata_o   = rdata_q[1];

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: read, round-robin tie, write with wait states,
// timeout, ack on the last timeout cycle, and reset in the middle of a transaction.
module tb_memory_arbiter;

  logic        clk, rst;
  logic        r0_req, r0_we, r0_ack, r0_err;
  logic [31:0] r0_addr, r0_wdata, r0_rdata;
  logic        r1_req, r1_we, r1_ack, r1_err;
  logic [31:0] r1_addr, r1_wdata, r1_rdata;
  logic        mem_en, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  memory_arbiter #(.TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .r0_req_i(r0_req), .r0_we_i(r0_we), .r0_addr_i(r0_addr), .r0_wdata_i(r0_wdata),
    .r0_ack_o(r0_ack), .r0_err_o(r0_err), .r0_rdata_o(r0_rdata),
    .r1_req_i(r1_req), .r1_we_i(r1_we), .r1_addr_i(r1_addr), .r1_wdata_i(r1_wdata),
    .r1_ack_o(r1_ack), .r1_err_o(r1_err), .r1_rdata_o(r1_rdata),
    .mem_enable_o(mem_en), .mem_write_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".en"},    {31'd0, mem_en}, 32'd0);
    chk({tag, ".we"},    {31'd0, mem_we}, 32'd0);
    chk({tag, ".addr"},  mem_addr, 32'd0);
    chk({tag, ".wdata"}, mem_wdata, 32'd0);
    chk({tag, ".acks"},  {28'd0, r0_ack, r0_err, r1_ack, r1_err}, 32'd0);
    chk({tag, ".rd0"},   r0_rdata, 32'd0);
    chk({tag, ".rd1"},   r1_rdata, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    tick; tick;
    chk_all_zero("reset");

    // single read, minimum latency
    rst = 0; r0_req = 1; r0_we = 0; r0_addr = 32'h8;
    tick;
    chk("rd.en", {31'd0, mem_en}, 32'd1);
    chk("rd.addr", mem_addr, 32'h8);
    chk("rd.we", {31'd0, mem_we}, 32'd0);
    r0_req = 0; mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    tick;
    chk("rd.ack", {30'd0, r0_ack, r0_err}, 32'b10);
    chk("rd.data", r0_rdata, 32'hDEADBEEF);
    chk("rd.en_resp", {31'd0, mem_en}, 32'd0);
    chk("rd.r1ack", {30'd0, r1_ack, r1_err}, 32'd0);
    tick;
    chk("rd.pulse", {31'd0, r0_ack}, 32'd0);
    // stray ack in IDLE with no request must not start anything
    tick;
    chk("idle.ack_ignored", {31'd0, mem_en}, 32'd0);

    // tie after reset: r0,r1,r0,r1 with the memory acking immediately
    rst = 1; mem_ack = 0;
    tick;
    rst = 0;
    r0_req = 1; r0_addr = 32'h100; r1_req = 1; r1_we = 0; r1_addr = 32'h200;
    mem_ack = 1;
    for (int k = 0; k < 4; k++) begin
      mem_rdata = 32'hA000_0000 + 32'(k);
      tick;
      chk($sformatf("tie%0d.addr", k), mem_addr, (k % 2 == 0) ? 32'h100 : 32'h200);
      tick;
      chk($sformatf("tie%0d.ack", k), {30'd0, r1_ack, r0_ack},
          (k % 2 == 0) ? 32'b01 : 32'b10);
      tick;
      chk($sformatf("tie%0d.pulse", k), {30'd0, r1_ack, r0_ack}, 32'd0);
      if (k == 3) begin
        r0_req = 0; r1_req = 0; mem_ack = 0;
      end
    end
    chk("tie.rd0", r0_rdata, 32'hA000_0002);
    chk("tie.rd1", r1_rdata, 32'hA000_0003);

    // r1 write, ack in the 4th BUSY cycle; r1 drops req and scrambles inputs meanwhile
    r1_req = 1; r1_we = 1; r1_addr = 32'h4; r1_wdata = 32'h55;
    for (int i = 1; i <= 4; i++) begin
      tick;
      chk($sformatf("wr.en%0d", i), {31'd0, mem_en}, 32'd1);
      chk($sformatf("wr.addr%0d", i), mem_addr, 32'h4);
      chk($sformatf("wr.we%0d", i), {31'd0, mem_we}, 32'd1);
      chk($sformatf("wr.wd%0d", i), mem_wdata, 32'h55);
      chk($sformatf("wr.noack%0d", i), {30'd0, r0_ack, r1_ack}, 32'd0);
      r1_req = 0; r1_we = 0; r1_addr = 32'hFFF; r1_wdata = 32'h0;
      if (i == 4) begin
        mem_ack = 1; mem_rdata = 32'hBAD0BAD0;
      end
    end
    tick;
    chk("wr.ack", {30'd0, r1_ack, r1_err}, 32'b10);
    chk("wr.r0ack", {30'd0, r0_ack, r0_err}, 32'd0);
    chk("wr.en_resp", {31'd0, mem_en}, 32'd0);
    chk("wr.rd1_kept", r1_rdata, 32'hA000_0003);
    mem_ack = 0;
    tick;

    // timeout: 16 BUSY cycles with no ack
    r0_req = 1; r0_we = 0; r0_addr = 32'h10; mem_rdata = 32'h5555AAAA;
    tick;
    r0_req = 0;
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("to.busy%0d", i), {30'd0, mem_en, r0_ack}, 32'b10);
      tick;
    end
    chk("to.busy16", {30'd0, mem_en, r0_ack}, 32'b10);
    tick;
    chk("to.ack", {30'd0, r0_ack, r0_err}, 32'b11);
    chk("to.rd0_kept", r0_rdata, 32'hA000_0002);
    tick;
    chk("to.pulse", {30'd0, r0_ack, r0_err}, 32'd0);

    // ack on the final timeout cycle wins over the timeout
    r0_req = 1;
    tick;
    r0_req = 0;
    for (int i = 1; i < 16; i++) tick;
    chk("late.busy16", {31'd0, mem_en}, 32'd1);
    mem_ack = 1; mem_rdata = 32'h12345678;
    tick;
    chk("late.ack", {30'd0, r0_ack, r0_err}, 32'b10);
    chk("late.data", r0_rdata, 32'h12345678);
    mem_ack = 0;
    tick;

    // reset while BUSY for r0; the following tie must go to r0 again
    r0_req = 1; r0_addr = 32'h20;
    tick;
    chk("rb.en", {31'd0, mem_en}, 32'd1);
    rst = 1; r0_req = 0;
    tick;
    chk_all_zero("rb.reset");
    rst = 0;
    tick;
    chk("rb.idle", {29'd0, mem_en, r0_ack, r1_ack}, 32'd0);
    r0_req = 1; r0_addr = 32'h300; r1_req = 1; r1_we = 0; r1_addr = 32'h400;
    tick;
    chk("rb.tie_addr", mem_addr, 32'h300);
    mem_ack = 1; r0_req = 0; r1_req = 0;
    tick;
    chk("rb.tie_ack", {30'd0, r1_ack, r0_ack}, 32'b01);
    mem_ack = 0;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
